simd_alu_pipe: RTL and testbench

- Parametrised, pipelined packed-SIMD ALU; next generation of the single-cycle 32-bit datapath ALU.
- Splits each operand word into LANES independent lanes of LANE_W bits.
- Adds per-lane flags, optional saturation, and valid/ready handshakes on both sides with a 2-stage pipeline.
- Sits between the vector register-file read stage and writeback.

---
 rtl/simd_alu_pipe.sv | 146 ++++++++++++++
 tb/tb_simd_alu_pipe.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_alu_pipe.sv
// simd_alu_pipe: two-stage packed-SIMD ALU with valid/ready handshakes.
// S1 captures operands and opcode; per-lane logic sits between S1 and S2;
// S2 holds result/flags and drives the output interface.
module simd_alu_pipe #(
  parameter  int LANES  = 4,
  parameter  int LANE_W = 8,
  localparam int W      = LANES * LANE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       op_a,
  input  logic [W-1:0]       op_b,
  input  logic [2:0]         control,
  input  logic               sat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       result,
  output logic [4*LANES-1:0] flags
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_MUL = 3'b100,
    OP_AVG = 3'b101,
    OP_THR = 3'b110,
    OP_SHL = 3'b111
  } op_e;

  localparam int             MSB      = LANE_W - 1;
  localparam int             SHW      = $clog2(LANE_W) + 1;
  localparam logic [SHW-1:0] SH_LIMIT = SHW'(LANE_W);

  logic               s1_valid;
  logic [W-1:0]       s1_a;
  logic [W-1:0]       s1_b;
  op_e                s1_op;
  logic               s1_sat;
  logic [W-1:0]       res_c;
  logic [4*LANES-1:0] flg_c;
  logic               s2_adv;

  // S2 can take new data when it is empty or its content is leaving.
  // in_ready is the only combinational path (from out_ready).
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  // S1: capture operands on an input transfer; drain when S2 takes the op.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
      s1_sat   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= op_a;
        s1_b   <= op_b;
        s1_op  <= op_e'(control);
        s1_sat <= sat;
      end
    end
  end

  // Per-lane datapath; no signal crosses a lane boundary.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0]   a;
    logic [LANE_W-1:0]   b;
    logic [LANE_W-1:0]   r;
    logic [LANE_W:0]     sum;
    logic [LANE_W-1:0]   diff;
    logic [2*LANE_W-1:0] prod;
    logic [SHW-1:0]      sh;
    logic                carry;
    logic                ovf;

    assign a    = s1_a[i*LANE_W +: LANE_W];
    assign b    = s1_b[i*LANE_W +: LANE_W];
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = a - b;
    assign prod = {{LANE_W{1'b0}}, a} * {{LANE_W{1'b0}}, b};
    assign sh   = b[SHW-1:0];

    // Opcode select; carry/ovf describe the unsaturated operation.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
      r     = '0;
      carry = 1'b0;
      ovf   = 1'b0;
      case (s1_op)
        OP_ADD: begin
          r     = sum[LANE_W-1:0];
          carry = sum[LANE_W];
          ovf   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
          if (s1_sat && carry) r = '1;
        end
        OP_SUB: begin
          r     = diff;
          carry = (a >= b);
          ovf   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
          if (s1_sat && !carry) r = '0;
        end
        OP_AND: r = a & b;
        OP_OR:  r = a | b;
        OP_MUL: begin
          r     = prod[LANE_W-1:0];
          carry = |prod[2*LANE_W-1:LANE_W];
          if (s1_sat && carry) r = '1;
        end
        // Halve first, then add the rounding bit: never exceeds LANE_W bits.
        OP_AVG: r = (a >> 1) + (b >> 1) + {{(LANE_W-1){1'b0}}, a[0] | b[0]};
        OP_THR: r = (a >= b) ? '1 : '0;
        OP_SHL: r = (sh >= SH_LIMIT) ? '0 : (a << sh);
        default: r = '0;
      endcase
    end

    assign res_c[i*LANE_W +: LANE_W] = r;
    assign flg_c[i*4 +: 4]           = {r[MSB], ~|r, carry, ovf};
  end

  // S2: load when advancing; hold result/flags stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= res_c;
        flags  <= flg_c;
      end
    end
  end

endmodule

// File: tb/tb_simd_alu_pipe.sv
// tb_simd_alu_pipe: directed and randomized checks of simd_alu_pipe against
// an integer-arithmetic lane model and an in-order scoreboard.
module tb_simd_alu_pipe;
  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int W      = LANES * LANE_W;
  localparam int FW     = 4 * LANES;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [W-1:0]  op_a      = '0;
  logic [W-1:0]  op_b      = '0;
  logic [2:0]    control   = '0;
  logic          sat       = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic [FW-1:0] flags;

  simd_alu_pipe #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .control(control), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_out = 0;
  int n_acc = 0;
  int last_acc = 0;
  bit done  = 1'b0;

  logic [W+FW-1:0] exp_q[$];
  logic [W-1:0]    res_log[$];
  logic [FW-1:0]   flg_log[$];
  int              cyc_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference lane model in plain integer arithmetic.
  function automatic logic [W+FW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op, input logic s);
    logic [W-1:0]  r;
    logic [FW-1:0] f;
    int m, half, av, bv, sa, sb, rv, sh, t;
    bit c, o;
    m = 1 << LANE_W;
    half = m / 2;
    r = '0;
    f = '0;
    for (int i = 0; i < LANES; i++) begin
      av = int'(a[i*LANE_W +: LANE_W]);
      bv = int'(b[i*LANE_W +: LANE_W]);
      sa = (av >= half) ? av - m : av;
      sb = (bv >= half) ? bv - m : bv;
      c = 1'b0;
      o = 1'b0;
      case (int'(op))
        0: begin
          rv = av + bv; c = (rv >= m); t = sa + sb; o = (t >= half) || (t < -half);
          if (c) rv = s ? m - 1 : rv - m;
        end
        1: begin
          rv = av - bv; c = (av >= bv); t = sa - sb; o = (t >= half) || (t < -half);
          if (!c) rv = s ? 0 : rv + m;
        end
        2: rv = av & bv;
        3: rv = av | bv;
        4: begin
          rv = av * bv; c = (rv >= m);
          rv = (c && s) ? m - 1 : rv % m;
        end
        5: rv = (av + bv + 1) / 2;
        6: rv = (av >= bv) ? m - 1 : 0;
        default: begin
          sh = bv % (2 * LANE_W);
          rv = (sh >= LANE_W) ? 0 : (av << sh) % m;
        end
      endcase
      r[i*LANE_W +: LANE_W] = LANE_W'(rv);
      f[i*4 +: 4] = {rv >= half, rv == 0, c, o};
    end
    return {r, f};
  endfunction

  // Output monitor: samples mid-cycle, compares against the scoreboard.
  always @(negedge clk) begin
    logic [W+FW-1:0] e;
    #2;
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      res_log.push_back(result);
      flg_log.push_back(flags);
      cyc_log.push_back(cyc);
      if (exp_q.size() == 0) check("spurious_output", 64'(result), 64'hx);
      else begin
        e = exp_q.pop_front();
        check("sb_result", 64'(result), 64'(e[W+FW-1:FW]));
        check("sb_flags", 64'(flags), 64'(e[FW-1:0]));
      end
    end
  end

  // Present one op and hold it until accepted (bounded).
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input logic s);
    int n;
    @(negedge clk);
    in_valid = 1'b1; op_a = a; op_b = b; control = op; sat = s;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(model(a, b, op, s));
      last_acc = cyc;
      n_acc++;
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    #3;
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n0, g;
    int acc[3];

    // Reset with a valid op presented: nothing must come out.
    in_valid = 1'b1; op_a = 32'h1234_5678; op_b = 32'h0101_0101;
    repeat (3) @(negedge clk);
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #3;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_no_output", 64'(n_out), 64'd0);

    // Add wrap vs saturate.
    out_ready = 1'b1;
    base = res_log.size();
    drive(32'hFF10_7F01, 32'h0110_0101, 3'b000, 1'b0);
    drive(32'hFF10_7F01, 32'h0110_0101, 3'b000, 1'b1);
    idle();
    repeat (4) @(negedge clk);
    #3;
    check("add_count", 64'(res_log.size() - base), 64'd2);
    check("add_wrap_res", 64'(res_log[base]), 64'h0020_8002);
    check("add_wrap_flg", 64'(flg_log[base]), 64'h6090);
    check("add_sat_res", 64'(res_log[base+1]), 64'hFF20_8002);
    check("add_sat_flg", 64'(flg_log[base+1]), 64'hA090);

    // Mixed ops back-to-back: values, 2-cycle latency, one per cycle.
    base = res_log.size();
    drive(32'h1010_0203, 32'h1010_0304, 3'b100, 1'b0); acc[0] = last_acc;
    drive(32'h00FF_0A03, 32'h00FF_0B04, 3'b101, 1'b0); acc[1] = last_acc;
    drive(32'h0101_0101, 32'h0008_0301, 3'b111, 1'b0); acc[2] = last_acc;
    idle();
    repeat (5) @(negedge clk);
    #3;
    check("mix_count", 64'(res_log.size() - base), 64'd3);
    check("mul_res", 64'(res_log[base]), 64'h0000_060C);
    check("mul_flg", 64'(flg_log[base]), 64'h6600);
    check("avg_res", 64'(res_log[base+1]), 64'h00FF_0B04);
    check("avg_flg", 64'(flg_log[base+1]), 64'h4800);
    check("shl_res", 64'(res_log[base+2]), 64'h0100_0802);
    check("shl_flg", 64'(flg_log[base+2]), 64'h0400);
    for (int j = 0; j < 3; j++) check("latency", 64'(cyc_log[base+j] - acc[j]), 64'd2);
    check("back_to_back", 64'(cyc_log[base+2] - cyc_log[base]), 64'd2);

    // Backpressure: 5 ops with out_ready low.
    @(negedge clk);
    out_ready = 1'b0;
    n0 = n_out; base = n_acc; done = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) drive($urandom(), $urandom(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        idle();
        done = 1'b1;
      end
    join_none
    repeat (6) @(negedge clk);
    #3;
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_accepted", 64'(n_acc - base), 64'd2);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_hold_res0", 64'(result), 64'(exp_q[0][W+FW-1:FW]));
    repeat (3) @(negedge clk);
    #3;
    check("bp_hold_res1", 64'(result), 64'(exp_q[0][W+FW-1:FW]));
    check("bp_hold_flg1", 64'(flags), 64'(exp_q[0][FW-1:0]));
    @(negedge clk);
    out_ready = 1'b1;
    g = 0;
    while (!done && g < 50) begin @(negedge clk); g++; end
    drain("bp_drain");
    check("bp_out_count", 64'(n_out - n0), 64'd5);

    // Full pipe, then 10 cycles of simultaneous accept and emit.
    @(negedge clk);
    out_ready = 1'b0;
    drive($urandom(), $urandom(), 3'b000, 1'b0);
    drive($urandom(), $urandom(), 3'b001, 1'b1);
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 10; k++) drive($urandom(), $urandom(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        idle();
        done = 1'b1;
      end
    join_none
    @(negedge clk);
    out_ready = 1'b1;
    n0 = n_out;
    for (int k = 0; k < 10; k++) begin
      #3;
      check("full_out_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    check("full_out_count", 64'(n_out - n0), 64'd10);
    g = 0;
    while (!done && g < 20) begin @(negedge clk); g++; end
    drain("full_drain");

    // Mid-operation reset with 2 ops in flight.
    @(negedge clk);
    out_ready = 1'b0;
    drive(32'h0102_0304, 32'h0506_0708, 3'b000, 1'b0);
    drive(32'h1111_1111, 32'h2222_2222, 3'b011, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    check("mid_pre_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_async_drop", 64'(out_valid), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    n0 = n_out;
    repeat (6) @(negedge clk);
    #3;
    check("mid_no_output", 64'(n_out - n0), 64'd0);
    check("mid_out_valid", 64'(out_valid), 64'd0);

    // Randomized traffic with random backpressure and bubbles.
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          if ($urandom_range(0, 3) == 0) idle();
          drive($urandom(), $urandom(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        idle();
        done = 1'b1;
      end
    join_none
    g = 0;
    while (!done && g < 5000) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      g++;
    end
    check("rand_done", 64'(done), 64'd1);
    @(negedge clk);
    out_ready = 1'b1;
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
